// File: rtl/park_occupancy_ctrl_if.sv
// park_occupancy_ctrl_if: sensor inputs, gate status and occupancy/display outputs of the parking controller.
interface park_occupancy_ctrl_if;
    logic       sensor_entrance_raw;
    logic       sensor_gate_raw;
    logic       sensor_leave_raw;
    logic       gate_open;
    logic       sensor_entrance;
    logic       sensor_exit;
    logic [3:0] occupied;
    logic       lot_full;
    logic       lot_empty;
    logic       count_err;
    logic [6:0] HEX_FREE;

    modport master (
        output sensor_entrance_raw, sensor_gate_raw, sensor_leave_raw, gate_open,
        input  sensor_entrance, sensor_exit, occupied, lot_full, lot_empty, count_err, HEX_FREE
    );
    modport slave (
        input  sensor_entrance_raw, sensor_gate_raw, sensor_leave_raw, gate_open,
        output sensor_entrance, sensor_exit, occupied, lot_full, lot_empty, count_err, HEX_FREE
    );
endinterface

// File: rtl/park_occupancy_ctrl.sv
// park_occupancy_ctrl: synchronizes and debounces lot sensors, counts parked cars and drives a free-space display.
module park_occupancy_ctrl #(
    parameter int CAPACITY        = 9,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic               clk,
    input logic               reset_n,
    park_occupancy_ctrl_if.slave bus
);
    localparam logic [3:0] CAP   = 4'(CAPACITY);
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    endfunction

    // bit 0 entrance, bit 1 past-gate, bit 2 leave
    logic [2:0] raw, sync1, sync2, deb;
    logic [2:1] deb_prev;
    logic [7:0] cnt [3];
    logic       entry, leave, err_next, full, empty, err;
    logic [3:0] occ, occ_next;
    logic [6:0] hex;

    assign raw = {bus.sensor_leave_raw, bus.sensor_gate_raw, bus.sensor_entrance_raw};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb[2:1];
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= sync2[i];
                end else cnt[i] <= cnt[i] + 8'd1;
            end
        end
    end

    assign entry = deb[1] & ~deb_prev[1] & bus.gate_open;
    assign leave = deb[2] & ~deb_prev[2];

    // simultaneous entry and leave cancel out without an error
    always_comb begin
        occ_next = (entry && !leave && occ != CAP) ? occ + 4'd1 :
                   (leave && !entry && occ != 4'd0) ? occ - 4'd1 : occ;
        err_next = (entry && !leave && occ == CAP) || (leave && !entry && occ == 4'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ   <= '0;
            err   <= 1'b0;
            full  <= 1'b0;
            empty <= 1'b1;
            hex   <= seg(CAP);
        end else begin
            occ   <= occ_next;
            err   <= err_next;
            full  <= occ == CAP;
            empty <= occ == 4'd0;
            hex   <= (occ == CAP) ? SEG_F : seg(CAP - occ);
        end
    end

    assign bus.sensor_entrance = deb[0] & ~full;
    assign bus.sensor_exit     = deb[1];
    assign bus.occupied        = occ;
    assign bus.lot_full        = full;
    assign bus.lot_empty       = empty;
    assign bus.count_err       = err;
    assign bus.HEX_FREE        = hex;
endmodule

// File: tb/tb_park_occupancy_ctrl.sv
// tb_park_occupancy_ctrl: directed scenarios plus randomized sensor traffic against a window-based reference model.
module tb_park_occupancy_ctrl;
    localparam int CAP = 3, DB = 4;

    logic clk = 1'b0, reset_n = 1'b0;
    park_occupancy_ctrl_if pif();
    park_occupancy_ctrl #(.CAPACITY(CAP), .DEBOUNCE_CYCLES(DB)) dut (.clk(clk), .reset_n(reset_n), .bus(pif));
    always #5 clk = ~clk;

    int total = 0, bad = 0, err_pulses = 0;
    bit checking = 0, ent_seen = 0;
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // model: raw sample history per sensor (index 0 newest), debounced values, count
    bit hist [3][16];
    bit m_deb [3];
    bit m_prev [3];
    int m_occ;
    bit m_err, m_full, m_empty;
    logic [6:0] m_hex;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 16; i++) hist[s][i] = 0;
            m_deb[s] = 0;
            m_prev[s] = 0;
        end
        m_occ = 0; m_err = 0; m_full = 0; m_empty = 1;
        m_hex = seg_tab[CAP];
    endfunction

    // a debounced value flips once the sensor, as seen two cycles late, has disagreed with it for DB samples in a row
    function automatic void model_step(bit r0, bit r1, bit r2, bit go);
        bit raw [3];
        bit ent, lv, all_diff;
        raw = '{r0, r1, r2};
        ent = m_deb[1] && !m_prev[1] && go;
        lv  = m_deb[2] && !m_prev[2];
        m_full  = (m_occ == CAP);
        m_empty = (m_occ == 0);
        m_hex   = m_full ? 7'b0001110 : seg_tab[CAP - m_occ];
        m_err = 0;
        if (ent && !lv) begin
            if (m_occ < CAP) m_occ++; else m_err = 1;
        end
        if (lv && !ent) begin
            if (m_occ > 0) m_occ--; else m_err = 1;
        end
        for (int s = 0; s < 3; s++) begin
            for (int i = 15; i > 0; i--) hist[s][i] = hist[s][i-1];
            hist[s][0] = raw[s];
            m_prev[s] = m_deb[s];
            all_diff = 1;
            for (int k = 0; k < DB; k++) if (hist[s][2+k] == m_deb[s]) all_diff = 0;
            if (all_diff) m_deb[s] = !m_deb[s];
        end
    endfunction

    always @(negedge clk) if (checking) begin
        check("occupied", pif.occupied, m_occ);
        check("lot_full", pif.lot_full, m_full);
        check("lot_empty", pif.lot_empty, m_empty);
        check("count_err", pif.count_err, m_err);
        check("hex_free", pif.HEX_FREE, m_hex);
        check("sensor_entrance", pif.sensor_entrance, m_deb[0] && !m_full);
        check("sensor_exit", pif.sensor_exit, m_deb[1]);
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            if (reset_n) model_step(pif.sensor_entrance_raw, pif.sensor_gate_raw, pif.sensor_leave_raw, pif.gate_open);
            @(negedge clk);
            if (pif.count_err) err_pulses++;
            if (pif.sensor_entrance) ent_seen = 1;
        end
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_occupied", pif.occupied, 0);
        check("rst_empty", pif.lot_empty, 1);
        check("rst_full", pif.lot_full, 0);
        check("rst_hex", pif.HEX_FREE, 7'b0110000);
        check("rst_exit", pif.sensor_exit, 0);
        tick(1);
        #2 reset_n = 1'b1;
    endtask

    task automatic entry();
        pif.gate_open = 1'b1;
        pif.sensor_gate_raw = 1'b1;
        tick(8);
        pif.sensor_gate_raw = 1'b0;
        tick(8);
    endtask

    task automatic leave();
        pif.sensor_leave_raw = 1'b1;
        tick(8);
        pif.sensor_leave_raw = 1'b0;
        tick(8);
    endtask

    initial begin
        int hold [3];
        pif.sensor_entrance_raw = 1'b0;
        pif.sensor_gate_raw = 1'b0;
        pif.sensor_leave_raw = 1'b0;
        pif.gate_open = 1'b0;
        model_reset();
        checking = 1;
        @(negedge clk);
        check("init_occupied", pif.occupied, 0);
        check("init_hex", pif.HEX_FREE, 7'b0110000);
        check("init_entrance", pif.sensor_entrance, 0);
        #2 reset_n = 1'b1;

        // gated entry: exit sensor after 6 cycles, count one cycle later, display one more
        pif.gate_open = 1'b1;
        pif.sensor_gate_raw = 1'b1;
        tick(5);
        check("s1_exit_early", pif.sensor_exit, 0);
        tick(1);
        check("s1_exit", pif.sensor_exit, 1);
        check("s1_occ_before", pif.occupied, 0);
        tick(1);
        check("s1_occ", pif.occupied, 1);
        tick(1);
        check("s1_hex", pif.HEX_FREE, 7'b0100100);
        pif.sensor_gate_raw = 1'b0;
        tick(8);

        // entrance glitch then a long hold
        ent_seen = 0;
        pif.sensor_entrance_raw = 1'b1;
        tick(3);
        pif.sensor_entrance_raw = 1'b0;
        tick(10);
        check("s2_glitch", ent_seen, 0);
        pif.sensor_entrance_raw = 1'b1;
        tick(5);
        check("s2_entr_early", pif.sensor_entrance, 0);
        tick(1);
        check("s2_entr", pif.sensor_entrance, 1);
        tick(4);
        pif.sensor_entrance_raw = 1'b0;
        tick(8);

        // fill the lot, then overflow
        entry();
        entry();
        check("s3_occ", pif.occupied, 3);
        check("s3_full", pif.lot_full, 1);
        check("s3_hex", pif.HEX_FREE, 7'b0001110);
        ent_seen = 0;
        pif.sensor_entrance_raw = 1'b1;
        tick(10);
        check("s3_entr_blocked", ent_seen, 0);
        pif.sensor_entrance_raw = 1'b0;
        tick(8);
        err_pulses = 0;
        entry();
        check("s3_overflow_err", err_pulses, 1);
        check("s3_overflow_occ", pif.occupied, 3);

        // coincident entry and leave at capacity
        err_pulses = 0;
        pif.gate_open = 1'b1;
        pif.sensor_gate_raw = 1'b1;
        pif.sensor_leave_raw = 1'b1;
        tick(8);
        pif.sensor_gate_raw = 1'b0;
        pif.sensor_leave_raw = 1'b0;
        tick(8);
        check("s5_occ", pif.occupied, 3);
        check("s5_err", err_pulses, 0);

        leave();
        leave();
        leave();
        check("drain_occ", pif.occupied, 0);
        check("drain_empty", pif.lot_empty, 1);

        // underflow, then an ungated gate edge
        err_pulses = 0;
        leave();
        check("s4_underflow_err", err_pulses, 1);
        check("s4_underflow_occ", pif.occupied, 0);
        err_pulses = 0;
        pif.gate_open = 1'b0;
        pif.sensor_gate_raw = 1'b1;
        tick(8);
        pif.sensor_gate_raw = 1'b0;
        tick(8);
        check("s4_ungated_occ", pif.occupied, 0);
        check("s4_ungated_err", err_pulses, 0);

        // reset in the middle of a leave debounce
        entry();
        entry();
        check("s6_occ_before", pif.occupied, 2);
        pif.sensor_leave_raw = 1'b1;
        tick(3);
        pif.sensor_leave_raw = 1'b0;
        do_reset();
        err_pulses = 0;
        tick(12);
        check("s6_occ_after", pif.occupied, 0);
        check("s6_err_after", err_pulses, 0);

        // random traffic with occasional resets
        hold = '{0, 0, 0};
        repeat (3000) begin
            if (hold[0] == 0) begin pif.sensor_entrance_raw = 1'($urandom_range(0, 1)); hold[0] = $urandom_range(1, 12); end
            if (hold[1] == 0) begin pif.sensor_gate_raw = 1'($urandom_range(0, 1)); hold[1] = $urandom_range(1, 12); end
            if (hold[2] == 0) begin pif.sensor_leave_raw = 1'($urandom_range(0, 1)); hold[2] = $urandom_range(1, 12); end
            for (int s = 0; s < 3; s++) hold[s]--;
            pif.gate_open = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 499) == 0) do_reset();
            tick(1);
        end

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
